// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-strobe signals for the unified-memory port arbiter.
// The shared tristate data bus is kept as a plain top-level port of the arbiter.
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic [WORD_SIZE-1:0] i_rdata;
    logic                 i_ready;
    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 d_ready;
    logic                 read_m;
    logic                 write_m;
    logic [WORD_SIZE-1:0] address;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output i_rdata, i_ready, d_rdata, d_ready, read_m, write_m, address
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  i_rdata, i_ready, d_rdata, d_ready, read_m, write_m, address
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto a single-ported memory,
// sequencing read_m/write_m/address and driving the shared data bus on writes.
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus,
    inout  wire  [WORD_SIZE-1:0] data
);
    localparam int CW = $clog2(MEM_LATENCY + 2);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]        starve_q, starve_d;
    logic                 winD_q, winD_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [WORD_SIZE-1:0] address_q, address_d;
    logic                 readM_q, readM_d;
    logic                 writeM_q, writeM_d;
    logic                 iReady_q, iReady_d;
    logic                 dReady_q, dReady_d;
    logic [WORD_SIZE-1:0] iRdata_q, iRdata_d;
    logic [WORD_SIZE-1:0] dRdata_q, dRdata_d;
    logic                 grantD, grantI;

    // D wins ties unless I has been passed over STARVE_LIMIT times in a row.
    assign grantD = bus.d_req && !(bus.i_req && (starve_q == SW'(STARVE_LIMIT)));
    assign grantI = bus.i_req && !grantD;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        starve_d  = starve_q;
        winD_d    = winD_q;
        wdata_d   = wdata_q;
        address_d = address_q;
        readM_d   = 1'b0;
        writeM_d  = 1'b0;
        iReady_d  = 1'b0;
        dReady_d  = 1'b0;
        iRdata_d  = iRdata_q;
        dRdata_d  = dRdata_q;
        case (state_q)
            IDLE: begin
                if (!bus.i_req || grantI) begin
                    starve_d = '0;
                end else if (grantD && starve_q != SW'(STARVE_LIMIT)) begin
                    starve_d = starve_q + 1'b1;
                end
                cnt_d = '0;
                if (grantD) begin
                    winD_d    = 1'b1;
                    address_d = bus.d_addr;
                    wdata_d   = bus.d_wdata;
                    if (bus.d_we) begin
                        writeM_d = 1'b1;
                        state_d  = WR;
                    end else begin
                        readM_d = 1'b1;
                        state_d = RD;
                    end
                end else if (grantI) begin
                    winD_d    = 1'b0;
                    address_d = bus.i_addr;
                    readM_d   = 1'b1;
                    state_d   = RD;
                end
            end
            RD: begin
                if (cnt_q == CW'(MEM_LATENCY)) begin
                    if (winD_q) begin
                        dRdata_d = data;
                        dReady_d = 1'b1;
                    end else begin
                        iRdata_d = data;
                        iReady_d = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    readM_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            WR: begin
                dReady_d = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            starve_q  <= '0;
            winD_q    <= 1'b0;
            wdata_q   <= '0;
            address_q <= '0;
            readM_q   <= 1'b0;
            writeM_q  <= 1'b0;
            iReady_q  <= 1'b0;
            dReady_q  <= 1'b0;
            iRdata_q  <= '0;
            dRdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            winD_q    <= winD_d;
            wdata_q   <= wdata_d;
            address_q <= address_d;
            readM_q   <= readM_d;
            writeM_q  <= writeM_d;
            iReady_q  <= iReady_d;
            dReady_q  <= dReady_d;
            iRdata_q  <= iRdata_d;
            dRdata_q  <= dRdata_d;
        end
    end

    // Bus is driven from the registered strobe, so reset releases it at once.
    assign data = writeM_q ? wdata_q : {WORD_SIZE{1'bz}};

    assign bus.read_m  = readM_q;
    assign bus.write_m = writeM_q;
    assign bus.address = address_q;
    assign bus.i_ready = iReady_q;
    assign bus.d_ready = dReady_q;
    assign bus.i_rdata = iRdata_q;
    assign bus.d_rdata = dRdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a 256-word memory model and a bus keeper
// that drives a fixed pattern whenever the memory is idle, exposing any contention.
module tb_mem_port_arbiter;
    localparam int W = 16;

    typedef struct {
        bit          isD;
        bit          isRead;
        logic [15:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    wire  [W-1:0]  data;
    logic [W-1:0]  tbDrive;
    logic [W-1:0]  mem [256];
    exp_t          sbQ [$];
    int            vectors = 0;
    int            miscompares = 0;

    mem_port_arbiter_if #(.WORD_SIZE(W)) ifc ();

    mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave),
        .data  (data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] preload(input int a);
        return 16'h9023 + 16'(a) * 16'h0111;
    endfunction

    // Memory returns data combinationally while read_m is high, otherwise the keeper pattern.
    assign tbDrive = ifc.read_m ? mem[ifc.address[7:0]] : 16'hA5A5;
    assign data    = ifc.write_m ? 16'bz : tbDrive;

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = preload(a);
    end

    always @(posedge clk) begin
        if (!reset && ifc.write_m) mem[ifc.address[7:0]] = data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Invariants every cycle, plus scoreboard pop on each ready pulse.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("rw_exclusive", 32'(ifc.read_m & ifc.write_m), 0);
            checkOutput("ready_exclusive", 32'(ifc.i_ready & ifc.d_ready), 0);
            if (!ifc.write_m) checkOutput("bus_released", 32'(data), 32'(tbDrive));
            if (ifc.i_ready || ifc.d_ready) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_ready", sbQ.size(), 1);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    checkOutput("grant_order", 32'(ifc.d_ready), 32'(e.isD));
                    if (e.isRead)
                        checkOutput("rdata", 32'(e.isD ? ifc.d_rdata : ifc.i_rdata), 32'(e.data));
                end
            end
        end
    end

    task automatic applyStimulus(input bit isD, input bit we, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] expData,
                                 input bit midChange);
        int lat;
        bit got;
        exp_t e;
        @(negedge clk);
        if (isD) begin
            ifc.d_req = 1'b1; ifc.d_we = we; ifc.d_addr = addr; ifc.d_wdata = wdata;
        end else begin
            ifc.i_req = 1'b1; ifc.i_addr = addr;
        end
        e.isD = isD; e.isRead = !we; e.data = expData;
        sbQ.push_back(e);
        lat = we ? 2 : 3;
        got = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (c < lat) begin
                checkOutput(we ? "write_m" : "read_m", 32'(we ? ifc.write_m : ifc.read_m), 1);
                checkOutput("address", 32'(ifc.address), 32'(addr));
                if (we) checkOutput("bus_wdata", 32'(data), 32'(wdata));
                if (midChange && c == 1) begin
                    ifc.d_addr  = addr + 16'd1;
                    ifc.d_wdata = 16'h5555;
                end
            end
            if (isD ? ifc.d_ready : ifc.i_ready) begin
                got = 1'b1;
                checkOutput("latency", c, lat);
                ifc.i_req = 1'b0;
                ifc.d_req = 1'b0;
            end
        end
        checkOutput("timeout", 32'(got), 1);
    endtask

    initial begin
        int n;
        exp_t e;
        ifc.i_req = 1'b0; ifc.i_addr = '0;
        ifc.d_req = 1'b0; ifc.d_we = 1'b0; ifc.d_addr = '0; ifc.d_wdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_read_m", 32'(ifc.read_m), 0);
        checkOutput("rst_write_m", 32'(ifc.write_m), 0);
        checkOutput("rst_address", 32'(ifc.address), 0);
        checkOutput("rst_i_ready", 32'(ifc.i_ready), 0);
        checkOutput("rst_d_ready", 32'(ifc.d_ready), 0);
        checkOutput("rst_i_rdata", 32'(ifc.i_rdata), 0);
        checkOutput("rst_d_rdata", 32'(ifc.d_rdata), 0);
        reset = 1'b0;

        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0, 16'h9023, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h00C7, 16'hBEEF, 16'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h00C7, 16'h0, 16'hBEEF, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h01C7, 16'h0, 16'hBEEF, 1'b0);
        checkOutput("d_rdata_hold", 32'(ifc.d_rdata), 32'hBEEF);

        // Operands changed mid-write must not reach memory.
        applyStimulus(1'b1, 1'b1, 16'h0030, 16'h1234, 16'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0, 16'h1234, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0031, 16'h0, preload(16'h31), 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0031, 16'h5555, 16'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0031, 16'h0, 16'h5555, 1'b0);

        // Both ports held: grant sequence D,D,D,D,I repeated.
        @(negedge clk);
        ifc.i_addr = 16'h0010; ifc.d_addr = 16'h0020; ifc.d_we = 1'b0;
        ifc.i_req = 1'b1; ifc.d_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            e.isD = (k % 5) != 4;
            e.isRead = 1'b1;
            e.data = e.isD ? preload(16'h20) : preload(16'h10);
            sbQ.push_back(e);
        end
        n = 0;
        for (int c = 0; c < 80 && n < 10; c++) begin
            @(negedge clk);
            if (ifc.i_ready || ifc.d_ready) n++;
            if (n == 10) begin
                ifc.i_req = 1'b0; ifc.d_req = 1'b0;
            end
        end
        checkOutput("starve_count", n, 10);
        repeat (4) @(negedge clk);
        checkOutput("sb_drained", sbQ.size(), 0);

        // Reset during the second RD cycle abandons the read.
        @(negedge clk);
        ifc.i_addr = 16'h0005; ifc.i_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("async_read_m", 32'(ifc.read_m), 0);
        checkOutput("async_address", 32'(ifc.address), 0);
        checkOutput("async_i_rdata", 32'(ifc.i_rdata), 0);
        checkOutput("async_d_rdata", 32'(ifc.d_rdata), 0);
        checkOutput("async_i_ready", 32'(ifc.i_ready), 0);
        ifc.i_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'h0005, 16'h0, preload(16'h05), 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h00C7, 16'h0, 16'hBEEF, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("sb_final", sbQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
